// File: rtl/bpu_pkg.sv
// Shared definitions for the branch resolve path: PC width, the layout of a
// queued branch record and the mispredict rule.
package bpu_pkg;

  localparam int PC_W     = 8;
  localparam int ENTRY_W  = 2 * PC_W + 1;

  // Record layout, MSB first: {pc, pred, ptgt}
  localparam int PTGT_LSB = 0;
  localparam int PRED_BIT = PC_W;
  localparam int PC_LSB   = PC_W + 1;

  // A branch was mispredicted if the direction differs, or if it was taken
  // and the predicted target does not match the real one.
  function automatic logic is_mispredict(input logic            pred,
                                         input logic            res_tk,
                                         input logic [PC_W-1:0] ptgt,
                                         input logic [PC_W-1:0] res_tg);
    return (pred != res_tk) || (res_tk && (ptgt != res_tg));
  endfunction

endpackage

// File: rtl/branch_info_fifo.sv
// Two-write / two-read circular buffer of predicted-branch records.
// The caller guarantees there is room for the writes and that rd_n <= count.
module branch_info_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en1,
  input  logic                   wr_en2,
  input  logic [W-1:0]           wr_data1,
  input  logic [W-1:0]           wr_data2,
  input  logic [1:0]             rd_n,
  output logic [W-1:0]           rd_data0,
  output logic [W-1:0]           rd_data1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] wr_addr2, rd_ptr_p1;
  logic [CW-1:0] count_q, count_d, wr_n;

  // Pointer and occupancy update; a clear empties the queue and drops writes.
  always_comb begin
    wr_n      = CW'(wr_en1) + CW'(wr_en2);
    wr_addr2  = wr_en1 ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_p1 = rd_ptr_q + AW'(1);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (clr) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(rd_n);
      wr_ptr_d = wr_ptr_q + AW'(wr_n);
      count_d  = count_q + wr_n - CW'(rd_n);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (wr_en1) mem_q[wr_ptr_q] <= wr_data1;
      if (wr_en2) mem_q[wr_addr2] <= wr_data2;
    end
  end

  assign rd_data0 = mem_q[rd_ptr_q];
  assign rd_data1 = mem_q[rd_ptr_p1];
  assign count    = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Queues predicted branches at decode, compares them with execute results,
// and drives the registered BPU update / flush outputs one cycle later.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push1,
  input  logic             push2,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  input  logic             pred1,
  input  logic             pred2,
  input  logic [PC_W-1:0]  ptgt1,
  input  logic [PC_W-1:0]  ptgt2,
  input  logic             res_v1,
  input  logic             res_v2,
  input  logic             res_tk1,
  input  logic             res_tk2,
  input  logic [PC_W-1:0]  res_tg1,
  input  logic [PC_W-1:0]  res_tg2,
  output logic             stall,
  output logic             branch1,
  output logic             branch2,
  output logic             branch_taken1,
  output logic             branch_taken2,
  output logic [PC_W-1:0]  pcM1,
  output logic [PC_W-1:0]  pcM2,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispred_count,
  output logic             err_underflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] head0, head1, l2_ent;
  logic [ENTRY_W-1:0] wr_data1, wr_data2;
  logic               wr_en1, wr_en2;
  logic [1:0]         pop_n;

  logic               l1_v, l2_v, mp1, mp2, upd2, flush_now, underflow_now;
  logic [PC_W-1:0]    redirect_d;

  logic               branch1_q, branch2_q, taken1_q, taken2_q, flush_q, err_q;
  logic [PC_W-1:0]    pcm1_q, pcm2_q, redirect_q;
  logic [CNT_W-1:0]   mcnt_q;

  branch_info_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush_now),
    .wr_en1   (wr_en1),
    .wr_en2   (wr_en2),
    .wr_data1 (wr_data1),
    .wr_data2 (wr_data2),
    .rd_n     (pop_n),
    .rd_data0 (head0),
    .rd_data1 (head1),
    .count    (count)
  );

  assign stall = (CW'(DEPTH) - count) < CW'(2);

  // Pair resolves with queued records, detect mispredicts and gate pushes.
  // A lone res_v2 consumes the head; a lane-1 mispredict makes lane 2 wrong-path.
  always_comb begin
    wr_data1                        = '0;
    wr_data1[PC_LSB +: PC_W]        = pc1;
    wr_data1[PRED_BIT]              = pred1;
    wr_data1[PTGT_LSB +: PC_W]      = ptgt1;
    wr_data2                        = '0;
    wr_data2[PC_LSB +: PC_W]        = pc2;
    wr_data2[PRED_BIT]              = pred2;
    wr_data2[PTGT_LSB +: PC_W]      = ptgt2;

    l2_ent = res_v1 ? head1 : head0;
    l1_v   = res_v1 && (count != '0);
    l2_v   = res_v2 && (res_v1 ? (count > CW'(1)) : (count != '0));

    mp1 = l1_v && is_mispredict(head0[PRED_BIT], res_tk1,
                                head0[PTGT_LSB +: PC_W], res_tg1);
    mp2 = l2_v && !mp1 && is_mispredict(l2_ent[PRED_BIT], res_tk2,
                                        l2_ent[PTGT_LSB +: PC_W], res_tg2);
    upd2      = l2_v && !mp1;
    flush_now = mp1 || mp2;

    underflow_now = (res_v1 && !l1_v) || (res_v2 && !l2_v);
    pop_n         = {1'b0, l1_v} + {1'b0, l2_v};

    wr_en1 = push1 && !stall && !flush_q && !flush_now;
    wr_en2 = push2 && !stall && !flush_q && !flush_now;

    if (mp1)
      redirect_d = res_tk1 ? res_tg1 : head0[PC_LSB +: PC_W] + PC_W'(1);
    else
      redirect_d = res_tk2 ? res_tg2 : l2_ent[PC_LSB +: PC_W] + PC_W'(1);
  end

  // Memory-stage update strobes, flush/redirect and status counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch1_q  <= 1'b0;
      branch2_q  <= 1'b0;
      taken1_q   <= 1'b0;
      taken2_q   <= 1'b0;
      pcm1_q     <= '0;
      pcm2_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      mcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      branch1_q  <= l1_v;
      taken1_q   <= l1_v && res_tk1;
      pcm1_q     <= l1_v ? head0[PC_LSB +: PC_W] : '0;
      branch2_q  <= upd2;
      taken2_q   <= upd2 && res_tk2;
      pcm2_q     <= upd2 ? l2_ent[PC_LSB +: PC_W] : '0;
      flush_q    <= flush_now;
      redirect_q <= flush_now ? redirect_d : '0;
      if (flush_now && (mcnt_q != '1))
        mcnt_q <= mcnt_q + CNT_W'(1);
      if (underflow_now)
        err_q <= 1'b1;
    end
  end

  assign branch1       = branch1_q;
  assign branch2       = branch2_q;
  assign branch_taken1 = taken1_q;
  assign branch_taken2 = taken2_q;
  assign pcM1          = pcm1_q;
  assign pcM2          = pcm2_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign mispred_count = mcnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import bpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic push1, push2, pred1, pred2, res_v1, res_v2, res_tk1, res_tk2;
  logic [7:0] pc1, pc2, ptgt1, ptgt2, res_tg1, res_tg2;
  logic stall, branch1, branch2, branch_taken1, branch_taken2, flush, err_underflow;
  logic [7:0] pcM1, pcM2, redirect_pc;
  logic [CNT_W-1:0] mispred_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .push1(push1), .push2(push2), .pc1(pc1), .pc2(pc2),
    .pred1(pred1), .pred2(pred2), .ptgt1(ptgt1), .ptgt2(ptgt2),
    .res_v1(res_v1), .res_v2(res_v2), .res_tk1(res_tk1), .res_tk2(res_tk2),
    .res_tg1(res_tg1), .res_tg2(res_tg2),
    .stall(stall), .branch1(branch1), .branch2(branch2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .pcM1(pcM1), .pcM2(pcM2), .flush(flush), .redirect_pc(redirect_pc),
    .mispred_count(mispred_count), .err_underflow(err_underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: a queue of outstanding predictions and the expected
  // registered outputs for the cycle after each edge.
  typedef struct {
    logic [7:0] pc;
    logic       pred;
    logic [7:0] ptgt;
  } ment_t;

  ment_t      mq[$];
  logic       e_b1, e_b2, e_t1, e_t2, e_fl, e_err;
  logic [7:0] e_pc1, e_pc2, e_rd;
  int         e_cnt;

  function automatic logic mis(input ment_t e, input logic tk, input logic [7:0] tg);
    return (e.pred != tk) || (tk && (e.ptgt != tg));
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int n, i2;
    logic v1, v2, m1, m2, st, pf;
    ment_t t;
    if (!reset) begin
      mq.delete();
      e_b1 = 0; e_b2 = 0; e_t1 = 0; e_t2 = 0; e_fl = 0; e_err = 0;
      e_pc1 = 0; e_pc2 = 0; e_rd = 0; e_cnt = 0;
    end else begin
      n  = mq.size();
      st = (DEPTH - n) < 2;
      v1 = res_v1 && (n >= 1);
      i2 = res_v1 ? 1 : 0;
      v2 = res_v2 && (n > i2);
      m1 = 0;
      m2 = 0;
      if (v1) m1 = mis(mq[0], res_tk1, res_tg1);
      if (v2 && !m1) m2 = mis(mq[i2], res_tk2, res_tg2);
      pf    = e_fl;
      e_b1  = v1;
      e_t1  = res_tk1;
      e_pc1 = v1 ? mq[0].pc : 8'h00;
      e_b2  = v2 && !m1;
      e_t2  = res_tk2;
      e_pc2 = v2 ? mq[i2].pc : 8'h00;
      e_fl  = m1 || m2;
      if (m1)      e_rd = res_tk1 ? res_tg1 : 8'(mq[0].pc + 8'd1);
      else if (m2) e_rd = res_tk2 ? res_tg2 : 8'(mq[i2].pc + 8'd1);
      if (e_fl && e_cnt < (2**CNT_W - 1)) e_cnt++;
      if ((int'(res_v1) + int'(res_v2)) > n) e_err = 1;
      if (e_fl) mq.delete();
      else begin
        if (v1) void'(mq.pop_front());
        if (v2) void'(mq.pop_front());
        if (!st && !pf) begin
          if (push1) begin t.pc = pc1; t.pred = pred1; t.ptgt = ptgt1; mq.push_back(t); end
          if (push2) begin t.pc = pc2; t.pred = pred2; t.ptgt = ptgt2; mq.push_back(t); end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("stall", stall, (DEPTH - mq.size()) < 2);
    chk("branch1", branch1, e_b1);
    chk("branch2", branch2, e_b2);
    chk("flush", flush, e_fl);
    chk("mispred_count", mispred_count, e_cnt);
    chk("err_underflow", err_underflow, e_err);
    if (e_b1) begin
      chk("branch_taken1", branch_taken1, e_t1);
      chk("pcM1", pcM1, e_pc1);
    end
    if (e_b2) begin
      chk("branch_taken2", branch_taken2, e_t2);
      chk("pcM2", pcM2, e_pc2);
    end
    if (e_fl) chk("redirect_pc", redirect_pc, e_rd);
  end

  task automatic idle();
    push1 = 0; push2 = 0; pred1 = 0; pred2 = 0; pc1 = 0; pc2 = 0; ptgt1 = 0; ptgt2 = 0;
    res_v1 = 0; res_v2 = 0; res_tk1 = 0; res_tk2 = 0; res_tg1 = 0; res_tg2 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic p1(input logic [7:0] pc, input logic pr, input logic [7:0] tg);
    push1 = 1; pc1 = pc; pred1 = pr; ptgt1 = tg;
  endtask

  task automatic p2(input logic [7:0] pc, input logic pr, input logic [7:0] tg);
    push2 = 1; pc2 = pc; pred2 = pr; ptgt2 = tg;
  endtask

  task automatic r1(input logic tk, input logic [7:0] tg);
    res_v1 = 1; res_tk1 = tk; res_tg1 = tg;
  endtask

  task automatic r2(input logic tk, input logic [7:0] tg);
    res_v2 = 1; res_tk2 = tk; res_tg2 = tg;
  endtask

  initial begin
    reset = 1;
    idle();
    #2 reset = 0;
    // Reset held with pushes active
    p1(8'hAA, 1, 8'hBB); p2(8'hAC, 0, 8'h00);
    repeat (3) cyc();
    chk("rst_stall", stall, 0);
    chk("rst_branch1", branch1, 0);
    chk("rst_flush", flush, 0);
    chk("rst_pcM1", pcM1, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_cnt", mispred_count, 0);
    chk("rst_err", err_underflow, 0);
    idle();
    reset = 1;
    cyc();
    chk("post_rst_stall", stall, 0);

    // Correct-path prediction
    p1(8'h10, 1, 8'h20); cyc(); idle();
    r1(1, 8'h20); cyc(); idle();
    chk("cp_branch1", branch1, 1);
    chk("cp_taken1", branch_taken1, 1);
    chk("cp_pcM1", pcM1, 8'h10);
    chk("cp_flush", flush, 0);
    cyc();
    chk("cp_pulse", branch1, 0);

    // Lane-1 mispredict kills lane 2; push in the flush cycle is dropped
    p1(8'h30, 0, 8'h00); p2(8'h31, 1, 8'h55); cyc(); idle();
    r1(1, 8'h40); r2(1, 8'h55); cyc(); idle();
    chk("l1mp_branch1", branch1, 1);
    chk("l1mp_branch2", branch2, 0);
    chk("l1mp_flush", flush, 1);
    chk("l1mp_redirect", redirect_pc, 8'h40);
    chk("l1mp_cnt", mispred_count, 1);
    p1(8'h77, 0, 8'h00); cyc(); idle();

    // Fill to stall, drop a push, then pop/push across the pointer wrap
    p1(8'h50, 0, 0); p2(8'h51, 0, 0); cyc();
    p1(8'h52, 0, 0); p2(8'h53, 0, 0); cyc();
    p1(8'h54, 0, 0); p2(8'h55, 0, 0); cyc(); idle();
    p1(8'h56, 0, 0); cyc(); idle();
    chk("full_stall", stall, 1);
    p1(8'h80, 0, 0); cyc(); idle();
    r1(0, 0); r2(0, 0); cyc(); idle();
    chk("drain_pcM1_a", pcM1, 8'h50);
    chk("drain_pcM2_a", pcM2, 8'h51);
    r1(0, 0); r2(0, 0); p1(8'h60, 0, 0); p2(8'h61, 0, 0); cyc(); idle();
    p1(8'h62, 0, 0); p2(8'h63, 0, 0); cyc(); idle();
    r1(0, 0); r2(0, 0); cyc(); idle();
    chk("wrap_pcM1", pcM1, 8'h54);
    chk("wrap_pcM2", pcM2, 8'h55);
    r1(0, 0); r2(0, 0); cyc(); idle();
    chk("wrap_pcM2_b", pcM2, 8'h60);
    r1(0, 0); r2(0, 0); cyc(); idle();
    r2(0, 0); cyc(); idle();
    chk("v2only_branch1", branch1, 0);
    chk("v2only_branch2", branch2, 1);
    chk("v2only_pcM2", pcM2, 8'h63);

    // PC wrap on not-taken redirect
    p1(8'hFF, 1, 8'h12); cyc(); idle();
    r1(0, 8'h00); cyc(); idle();
    chk("pcwrap_flush", flush, 1);
    chk("pcwrap_redirect", redirect_pc, 8'h00);
    chk("pcwrap_cnt", mispred_count, 2);
    cyc();

    // Lane-2-only mispredict: both updates issued
    p1(8'h20, 0, 0); p2(8'h21, 0, 0); cyc(); idle();
    r1(0, 0); r2(1, 8'h99); cyc(); idle();
    chk("l2mp_branch1", branch1, 1);
    chk("l2mp_branch2", branch2, 1);
    chk("l2mp_redirect", redirect_pc, 8'h99);
    chk("l2mp_cnt", mispred_count, 3);
    cyc();

    // Taken with wrong target
    p1(8'h40, 1, 8'h44); cyc(); idle();
    r1(1, 8'h45); cyc(); idle();
    chk("tgt_flush", flush, 1);
    chk("tgt_redirect", redirect_pc, 8'h45);
    cyc();

    // Underflow on empty queue, sticky
    r1(1, 8'h00); cyc(); idle();
    chk("uf_branch1", branch1, 0);
    chk("uf_err", err_underflow, 1);
    cyc(); cyc();
    chk("uf_sticky", err_underflow, 1);

    // Counter saturation
    for (int i = 0; i < 14; i++) begin
      p1(8'(i), 0, 0); cyc(); idle();
      r1(1, 8'(i + 3)); cyc(); idle();
      cyc();
    end
    chk("sat_cnt", mispred_count, 15);

    // Reset mid-operation drops pending strobes and queue contents
    p1(8'h10, 0, 0); p2(8'h11, 0, 0); cyc(); idle();
    p1(8'h12, 0, 0); r1(0, 0); cyc(); idle();
    #2 reset = 0;
    #1;
    chk("midrst_branch1", branch1, 0);
    chk("midrst_err", err_underflow, 0);
    chk("midrst_cnt", mispred_count, 0);
    cyc();
    reset = 1;
    cyc();
    r1(0, 0); cyc(); idle();
    chk("midrst_lost_b1", branch1, 0);
    chk("midrst_lost_err", err_underflow, 1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
